// File: rtl/frame_loader.sv
// Frame loader: accepts a pixel stream and writes it into frame RAM.
// Optional double buffering via FRAME_LOADER_DOUBLE_BUF_EN (default: single bank).
module frame_loader #(
  parameter int N = 10,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pix_valid,
  output logic         pix_ready,
  input  logic         pix_sof,
  input  logic [M-1:0] pix_rgb,
  input  logic         scan_frame_start,
  output logic         we,
  output logic [N:0]   adr_out,
  output logic [M-1:0] din_out,
  output logic         disp_bank,
  output logic         frame_done,
  output logic         sof_err
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t       state_q;
  logic [N-1:0] count_q;
  logic         hs;
  logic         wr_bank;
  logic [N-1:0] wr_idx;

  assign pix_ready = (state_q != WAIT_SWAP);
  assign hs        = pix_valid && pix_ready;
  assign wr_idx    = pix_sof ? '0 : count_q;

`ifdef FRAME_LOADER_DOUBLE_BUF_EN
  // Always write the bank the scan engine is not reading.
  assign wr_bank = ~disp_bank;
`else
  assign wr_bank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      we         <= 1'b0;
      adr_out    <= '0;
      din_out    <= '0;
      disp_bank  <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            if (pix_sof) begin
              we      <= 1'b1;
              adr_out <= {wr_bank, wr_idx};
              din_out <= pix_rgb;
              count_q <= {{(N-1){1'b0}}, 1'b1};
              state_q <= LOAD;
            end else begin
              sof_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            we      <= 1'b1;
            adr_out <= {wr_bank, wr_idx};
            din_out <= pix_rgb;
            if (pix_sof) begin
              count_q <= {{(N-1){1'b0}}, 1'b1};
            end else begin
              // Wraps to zero on the last pixel of the frame.
              count_q <= count_q + 1'b1;
              if (count_q == '1) begin
                frame_done <= 1'b1;
`ifdef FRAME_LOADER_DOUBLE_BUF_EN
                state_q    <= WAIT_SWAP;
`else
                state_q    <= IDLE;
`endif
              end
            end
          end
        end
        WAIT_SWAP: begin
`ifdef FRAME_LOADER_DOUBLE_BUF_EN
          if (scan_frame_start) begin
            disp_bank <= ~disp_bank;
            state_q   <= IDLE;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// Directed self-checking bench for frame_loader; expectations follow the
// FRAME_LOADER_DOUBLE_BUF_EN setting of the build.
module tb_frame_loader;
  localparam int N = 10;
  localparam int M = 3;
`ifdef FRAME_LOADER_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_sof;
  logic [M-1:0] pix_rgb;
  logic         scan_frame_start;
  logic         we;
  logic [N:0]   adr_out;
  logic [M-1:0] din_out;
  logic         disp_bank;
  logic         frame_done;
  logic         sof_err;

  int n_chk = 0;
  int n_err = 0;
  logic exp_disp = 1'b0;

  frame_loader #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_rgb(pix_rgb), .scan_frame_start(scan_frame_start),
    .we(we), .adr_out(adr_out), .din_out(din_out), .disp_bank(disp_bank),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one pixel for one cycle, then check the registered write.
  task automatic pix(input logic sof, input logic [2:0] rgb, input int idx,
                     input logic done, input logic scan);
    logic bank;
    bank = DB ? ~exp_disp : 1'b0;
    pix_valid = 1'b1; pix_sof = sof; pix_rgb = rgb; scan_frame_start = scan;
    @(negedge clk);
    pix_valid = 1'b0; pix_sof = 1'b0; scan_frame_start = 1'b0;
    chk("pix_we", 32'(we), 32'd1);
    chk("pix_adr", 32'(adr_out), (32'(bank) << N) | 32'(idx));
    chk("pix_din", 32'(din_out), 32'(rgb));
    chk("pix_done", 32'(frame_done), 32'(done));
  endtask

  task automatic frame(input logic scan_on_last);
    for (int i = 0; i < (1 << N); i++)
      pix(i == 0, i[2:0], i, i == (1 << N) - 1, scan_on_last && (i == (1 << N) - 1));
  endtask

  task automatic pulse_scan();
    scan_frame_start = 1'b1;
    @(negedge clk);
    scan_frame_start = 1'b0;
    if (DB) exp_disp = ~exp_disp;
    chk("scan_we", 32'(we), 32'd0);
    chk("scan_disp", 32'(disp_bank), 32'(exp_disp));
    chk("scan_ready", 32'(pix_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_rgb = '0; scan_frame_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_adr", 32'(adr_out), 32'd0);
    chk("rst_din", 32'(din_out), 32'd0);
    chk("rst_disp", 32'(disp_bank), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_soferr", 32'(sof_err), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd1);
    reset = 1'b0;

    // Full frame into the back bank.
    frame(1'b0);
    chk("f1_ready", 32'(pix_ready), DB ? 32'd0 : 32'd1);
    if (DB) begin
      // Pixels offered while waiting for the swap are ignored.
      pix_valid = 1'b1; pix_sof = 1'b1; pix_rgb = 3'd6;
      @(negedge clk);
      pix_valid = 1'b0; pix_sof = 1'b0;
      chk("wait_we", 32'(we), 32'd0);
      chk("wait_ready", 32'(pix_ready), 32'd0);
    end
    pulse_scan();

    // Pixel without start-of-frame in IDLE is dropped.
    pix_valid = 1'b1; pix_sof = 1'b0; pix_rgb = 3'd5;
    @(negedge clk);
    pix_valid = 1'b0;
    chk("nosof_we", 32'(we), 32'd0);
    chk("nosof_err", 32'(sof_err), 32'd1);

    // Second frame; a scan pulse on the final pixel must not swap.
    frame(1'b1);
    chk("f2_soferr", 32'(sof_err), 32'd1);
    chk("f2_disp", 32'(disp_bank), 32'(exp_disp));
    chk("f2_ready", 32'(pix_ready), DB ? 32'd0 : 32'd1);
    pulse_scan();

    // Restart mid-frame; scan pulse during LOAD is ignored.
    for (int i = 0; i < 500; i++) pix(i == 0, i[2:0], i, 1'b0, i == 250);
    chk("load_disp", 32'(disp_bank), 32'(exp_disp));
    pix(1'b1, 3'd7, 0, 1'b0, 1'b0);
    pix(1'b0, 3'd2, 1, 1'b0, 1'b0);
    for (int i = 2; i < 300; i++) pix(1'b0, i[2:0], i, 1'b0, 1'b0);

    // Reset mid-frame with a pixel on offer.
    reset = 1'b1; pix_valid = 1'b1; pix_sof = 1'b0; pix_rgb = 3'd4;
    @(negedge clk);
    chk("mrst_we", 32'(we), 32'd0);
    chk("mrst_adr", 32'(adr_out), 32'd0);
    chk("mrst_din", 32'(din_out), 32'd0);
    chk("mrst_disp", 32'(disp_bank), 32'd0);
    chk("mrst_done", 32'(frame_done), 32'd0);
    chk("mrst_soferr", 32'(sof_err), 32'd0);
    chk("mrst_ready", 32'(pix_ready), 32'd1);
    reset = 1'b0; pix_valid = 1'b0;
    exp_disp = 1'b0;
    @(negedge clk);
    chk("post_rst_we", 32'(we), 32'd0);
    pix(1'b1, 3'd3, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter N, default 10, pixel address width (2**N pixels per frame).
REQ-002 Parameter M, default 3, colour bits per pixel ({B,G,R}).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pix_valid  input  1  host pixel strobe.
REQ-006 pix_ready  output  1  loader can accept a pixel this cycle.
REQ-007 pix_sof  input  1  qualifies the current pixel as frame start (address 0).
REQ-008 pix_rgb  input  M  pixel colour.
REQ-009 scan_frame_start  input  1  one-cycle pulse from the scan engine at row-0 blank.
REQ-010 we  output  1  frame RAM write enable.
REQ-011 adr_out  output  N+1  RAM write address: {bank, pixel index}.
REQ-012 din_out  output  M  RAM write data.
REQ-013 disp_bank  output  1  bank the scan engine reads.
REQ-014 frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.
REQ-015 sof_err  output  1  sticky: a pixel without pix_sof arrived while IDLE.

Function
REQ-016 A handshake occurs in any cycle with pix_valid && pix_ready.
REQ-017 States SHALL be IDLE, LOAD and WAIT_SWAP; pix_ready = 1 in IDLE and LOAD, 0 in WAIT_SWAP.
REQ-018 IDLE: handshake with pix_sof -> write to index 0, count <= 1, go to LOAD; handshake without pix_sof -> pixel dropped, sof_err <= 1, stay in IDLE.
REQ-019 LOAD: handshake without pix_sof -> write to index count, count <= count + 1.
REQ-020 LOAD: handshake with pix_sof -> restart: write to index 0, count <= 1, stay in LOAD.
REQ-021 LOAD: handshake writing index 2**N-1 -> frame_done pulses in the same cycle as that we; count wraps to 0; next state is WAIT_SWAP.
REQ-022 Writes SHALL be registered: we, adr_out and din_out are valid exactly one cycle after the handshake, and we is high for exactly one cycle per accepted pixel.
REQ-023 The bank field of adr_out SHALL equal ~disp_bank, so the displayed bank is never written.
REQ-024 WAIT_SWAP: on scan_frame_start, disp_bank toggles and the state returns to IDLE on the next edge; pix_valid is ignored.
REQ-025 If scan_frame_start arrives in IDLE or LOAD, it SHALL be ignored (no toggle).
REQ-026 If scan_frame_start arrives in the same cycle the state enters WAIT_SWAP, it SHALL NOT cause a swap; only pulses seen while in WAIT_SWAP count.
REQ-027 Index arithmetic is N-bit modulo 2**N; no other overflow is possible.

Reset
REQ-028 reset SHALL force IDLE, count = 0, we = 0, adr_out = 0, din_out = 0, disp_bank = 0, frame_done = 0, sof_err = 0, pix_ready = 1 in the following cycle.
REQ-029 A reset asserted mid-frame SHALL abandon the frame with no further writes; the suppressed write SHALL NOT appear after reset.

Configuration
REQ-030 Macro FRAME_LOADER_DOUBLE_BUF_EN defined: double buffering per REQ-023 to REQ-026.
REQ-031 Macro undefined: single bank; the bank bit of adr_out and disp_bank are held at 0; WAIT_SWAP is unreachable; after frame_done the state returns to IDLE; scan_frame_start is ignored.

Verification
REQ-032 reset, then 1024 pixels with pix_sof on the first, rgb = index[2:0] -> writes at adr_out 0x400..0x7FF, data = index[2:0], frame_done on the 0x7FF write, pix_ready = 0 afterwards.
REQ-033 Continue from REQ-032, pulse scan_frame_start -> disp_bank = 1, IDLE; next frame writes 0x000..0x3FF.
REQ-034 In IDLE, pixel without pix_sof (rgb = 5) -> no we, sof_err = 1 and stays 1 after a later valid frame.
REQ-035 500 pixels, then one with pix_sof and rgb = 7 -> write 7 at index 0, next pixel goes to index 1, no frame_done.
REQ-036 reset asserted after 300 pixels -> we = 0 next cycle, all outputs at reset values, disp_bank = 0.
REQ-037 Macro undefined: 1024 pixels -> addresses 0x000..0x3FF, frame_done, pix_ready stays 1, disp_bank stays 0 despite scan_frame_start.
